// File: rtl/rvh_l1d_amo_ctrl.sv
// L1D AMO sequencer: read the target doubleword, compute on the shared ALU,
// write back under a byte mask and return the old value. One AMO in flight.
module rvh_l1d_amo_ctrl #(
  parameter int XLEN         = 64,
  parameter int PADDR_W      = 56,
  parameter int ID_W         = 4,
  parameter int ALU_OP_WIDTH = 5,
  // ALU opcode encodings are parameters so the core's uop encoding binds at integration
  parameter logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 'd0,
  parameter logic [ALU_OP_WIDTH-1:0] ALU_SLT  = 'd2,
  parameter logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 'd3,
  parameter logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 'd4,
  parameter logic [ALU_OP_WIDTH-1:0] ALU_OR   = 'd6,
  parameter logic [ALU_OP_WIDTH-1:0] ALU_AND  = 'd7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_vld_i,
  output logic                    req_rdy_o,
  input  logic [ID_W-1:0]         req_id_i,
  input  logic [3:0]              req_amo_op_i,
  input  logic                    req_w_i,
  input  logic [PADDR_W-1:0]      req_addr_i,
  input  logic [XLEN-1:0]         req_data_i,
  output logic                    rd_vld_o,
  input  logic                    rd_rdy_i,
  output logic [PADDR_W-1:0]      rd_addr_o,
  input  logic                    rd_resp_vld_i,
  input  logic [XLEN-1:0]         rd_resp_data_i,
  output logic [ALU_OP_WIDTH-1:0] alu_opcode_o,
  output logic                    alu_op_w_o,
  output logic [XLEN-1:0]         alu_operand0_o,
  output logic [XLEN-1:0]         alu_operand1_o,
  input  logic [XLEN-1:0]         alu_wb_data_i,
  output logic                    wr_vld_o,
  input  logic                    wr_rdy_i,
  output logic [PADDR_W-1:0]      wr_addr_o,
  output logic [XLEN-1:0]         wr_data_o,
  output logic [XLEN/8-1:0]       wr_mask_o,
  output logic                    resp_vld_o,
  input  logic                    resp_rdy_i,
  output logic [ID_W-1:0]         resp_id_o,
  output logic [XLEN-1:0]         resp_data_o,
  output logic                    resp_err_o,
  output logic                    busy_o,
  output logic [2:0]              dbg_state_o
);

  // Handshakes: a payload transfers on the rising edge where valid and ready
  // are both high; valid and payload stay stable until that edge.

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_CMP     = 3'd3;
  localparam logic [2:0] S_EXEC    = 3'd4;
  localparam logic [2:0] S_WR      = 3'd5;
  localparam logic [2:0] S_RESP    = 3'd6;

  localparam logic [3:0] OP_SWAP = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_MIN  = 4'd5;
  localparam logic [3:0] OP_MAX  = 4'd6;
  localparam logic [3:0] OP_MINU = 4'd7;
  localparam logic [3:0] OP_MAXU = 4'd8;

  logic [2:0]         state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [3:0]         op_q, op_d;
  logic               w_q, w_d;
  logic [PADDR_W-1:2] addr_q, addr_d;
  logic [XLEN-1:0]    rs2_q, rs2_d;
  logic [XLEN-1:0]    old_q, old_d;
  logic [XLEN-1:0]    new_q, new_d;
  logic               lt_q, lt_d;
  logic               err_q, err_d;

  logic            req_bad;
  logic            is_minmax;
  logic            signed_cmp;
  logic [31:0]     rd_word;
  logic [XLEN-1:0] exec_result;

  assign req_bad    = (req_w_i ? (|req_addr_i[1:0]) : (|req_addr_i[2:0])) || (req_amo_op_i > OP_MAXU);
  assign is_minmax  = (op_q >= OP_MIN);
  assign signed_cmp = (op_q == OP_MIN) || (op_q == OP_MAX);
  assign rd_word    = addr_q[2] ? rd_resp_data_i[XLEN-1:32] : rd_resp_data_i[31:0];

  always_comb begin
    exec_result = alu_wb_data_i;
    case (op_q)
      OP_SWAP:         exec_result = rs2_q;
      OP_MIN, OP_MINU: exec_result = lt_q ? old_q : rs2_q;
      OP_MAX, OP_MAXU: exec_result = lt_q ? rs2_q : old_q;
      default:         exec_result = alu_wb_data_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    op_d    = op_q;
    w_d     = w_q;
    addr_d  = addr_q;
    rs2_d   = rs2_q;
    old_d   = old_q;
    new_d   = new_q;
    lt_d    = lt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_vld_i) begin
          id_d    = req_id_i;
          op_d    = req_amo_op_i;
          w_d     = req_w_i;
          addr_d  = req_addr_i[PADDR_W-1:2];
          rs2_d   = req_data_i;
          old_d   = '0;
          new_d   = '0;
          lt_d    = 1'b0;
          err_d   = req_bad;
          state_d = req_bad ? S_RESP : S_RD_REQ;
        end
      end
      S_RD_REQ:  if (rd_rdy_i) state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (rd_resp_vld_i) begin
          old_d   = w_q ? {{(XLEN-32){rd_word[31]}}, rd_word} : rd_resp_data_i;
          state_d = is_minmax ? S_CMP : S_EXEC;
        end
      end
      S_CMP: begin
        lt_d    = alu_wb_data_i[0];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        new_d   = exec_result;
        state_d = S_WR;
      end
      S_WR:    if (wr_rdy_i) state_d = S_RESP;
      S_RESP:  if (resp_rdy_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      op_q    <= '0;
      w_q     <= 1'b0;
      addr_q  <= '0;
      rs2_q   <= '0;
      old_q   <= '0;
      new_q   <= '0;
      lt_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      op_q    <= op_d;
      w_q     <= w_d;
      addr_q  <= addr_d;
      rs2_q   <= rs2_d;
      old_q   <= old_d;
      new_q   <= new_d;
      lt_q    <= lt_d;
      err_q   <= err_d;
    end
  end

  // .W compares see 32-bit values widened to match the signedness of the op
  always_comb begin
    alu_opcode_o   = ALU_ADD;
    alu_op_w_o     = 1'b0;
    alu_operand0_o = '0;
    alu_operand1_o = '0;
    if (state_q == S_CMP) begin
      alu_opcode_o = signed_cmp ? ALU_SLT : ALU_SLTU;
      if (!w_q) begin
        alu_operand0_o = old_q;
        alu_operand1_o = rs2_q;
      end else if (signed_cmp) begin
        alu_operand0_o = old_q;
        alu_operand1_o = {{(XLEN-32){rs2_q[31]}}, rs2_q[31:0]};
      end else begin
        alu_operand0_o = {{(XLEN-32){1'b0}}, old_q[31:0]};
        alu_operand1_o = {{(XLEN-32){1'b0}}, rs2_q[31:0]};
      end
    end else if (state_q == S_EXEC) begin
      alu_operand0_o = old_q;
      alu_operand1_o = rs2_q;
      case (op_q)
        OP_ADD: begin
          alu_opcode_o = ALU_ADD;
          alu_op_w_o   = w_q;
        end
        OP_XOR:  alu_opcode_o = ALU_XOR;
        OP_AND:  alu_opcode_o = ALU_AND;
        OP_OR:   alu_opcode_o = ALU_OR;
        default: alu_opcode_o = ALU_ADD;
      endcase
    end
  end

  assign req_rdy_o   = (state_q == S_IDLE);
  assign rd_vld_o    = (state_q == S_RD_REQ);
  assign rd_addr_o   = {addr_q[PADDR_W-1:3], 3'b000};
  assign wr_vld_o    = (state_q == S_WR);
  assign wr_addr_o   = {addr_q[PADDR_W-1:3], 3'b000};
  assign wr_data_o   = !wr_vld_o ? '0 : (w_q ? {new_q[31:0], new_q[31:0]} : new_q);
  assign wr_mask_o   = !wr_vld_o ? '0 : (w_q ? (addr_q[2] ? 8'hF0 : 8'h0F) : 8'hFF);
  assign resp_vld_o  = (state_q == S_RESP);
  assign resp_id_o   = id_q;
  assign resp_data_o = old_q;
  assign resp_err_o  = resp_vld_o && err_q;
  assign busy_o      = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rvh_l1d_amo_ctrl.sv
// Directed + small random bench for rvh_l1d_amo_ctrl with a memory responder,
// an ALU model and a scoreboard of expected reads, writes and responses.
module tb_rvh_l1d_amo_ctrl;
  localparam int XLEN = 64;
  localparam int PADDR_W = 56;
  localparam int ID_W = 4;
  localparam int AOW = 5;
  localparam logic [AOW-1:0] A_ADD = 5'd0, A_SLT = 5'd2, A_SLTU = 5'd3;
  localparam logic [AOW-1:0] A_XOR = 5'd4, A_OR = 5'd6, A_AND = 5'd7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_vld_i = 1'b0;
  logic req_rdy_o;
  logic [ID_W-1:0] req_id_i = '0;
  logic [3:0] req_amo_op_i = '0;
  logic req_w_i = 1'b0;
  logic [PADDR_W-1:0] req_addr_i = '0;
  logic [XLEN-1:0] req_data_i = '0;
  logic rd_vld_o;
  logic rd_rdy_i = 1'b1;
  logic [PADDR_W-1:0] rd_addr_o;
  logic rd_resp_vld_i = 1'b0;
  logic [XLEN-1:0] rd_resp_data_i = '0;
  logic [AOW-1:0] alu_opcode_o;
  logic alu_op_w_o;
  logic [XLEN-1:0] alu_operand0_o, alu_operand1_o;
  logic [XLEN-1:0] alu_wb_data_i;
  logic wr_vld_o;
  logic wr_rdy_i = 1'b1;
  logic [PADDR_W-1:0] wr_addr_o;
  logic [XLEN-1:0] wr_data_o;
  logic [XLEN/8-1:0] wr_mask_o;
  logic resp_vld_o;
  logic resp_rdy_i = 1'b1;
  logic [ID_W-1:0] resp_id_o;
  logic [XLEN-1:0] resp_data_o;
  logic resp_err_o;
  logic busy_o;
  logic [2:0] dbg_state_o;

  rvh_l1d_amo_ctrl #(
    .XLEN(XLEN), .PADDR_W(PADDR_W), .ID_W(ID_W), .ALU_OP_WIDTH(AOW),
    .ALU_ADD(A_ADD), .ALU_SLT(A_SLT), .ALU_SLTU(A_SLTU),
    .ALU_XOR(A_XOR), .ALU_OR(A_OR), .ALU_AND(A_AND)
  ) dut (
    .clk(clk), .rst(rst),
    .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o), .req_id_i(req_id_i),
    .req_amo_op_i(req_amo_op_i), .req_w_i(req_w_i), .req_addr_i(req_addr_i),
    .req_data_i(req_data_i),
    .rd_vld_o(rd_vld_o), .rd_rdy_i(rd_rdy_i), .rd_addr_o(rd_addr_o),
    .rd_resp_vld_i(rd_resp_vld_i), .rd_resp_data_i(rd_resp_data_i),
    .alu_opcode_o(alu_opcode_o), .alu_op_w_o(alu_op_w_o),
    .alu_operand0_o(alu_operand0_o), .alu_operand1_o(alu_operand1_o),
    .alu_wb_data_i(alu_wb_data_i),
    .wr_vld_o(wr_vld_o), .wr_rdy_i(wr_rdy_i), .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o), .wr_mask_o(wr_mask_o),
    .resp_vld_o(resp_vld_o), .resp_rdy_i(resp_rdy_i), .resp_id_o(resp_id_o),
    .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
    .busy_o(busy_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // shared L1D ALU model
  logic [XLEN-1:0] alu_sum;
  always_comb begin
    alu_sum = alu_operand0_o + alu_operand1_o;
    alu_wb_data_i = '0;
    case (alu_opcode_o)
      A_ADD:  alu_wb_data_i = alu_op_w_o ? {{32{alu_sum[31]}}, alu_sum[31:0]} : alu_sum;
      A_SLT:  alu_wb_data_i = {63'd0, $signed(alu_operand0_o) < $signed(alu_operand1_o)};
      A_SLTU: alu_wb_data_i = {63'd0, alu_operand0_o < alu_operand1_o};
      A_XOR:  alu_wb_data_i = alu_operand0_o ^ alu_operand1_o;
      A_OR:   alu_wb_data_i = alu_operand0_o | alu_operand1_o;
      A_AND:  alu_wb_data_i = alu_operand0_o & alu_operand1_o;
      default: alu_wb_data_i = '0;
    endcase
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // scoreboard
  logic [PADDR_W-1:0] exp_rd_addr_q[$];
  logic [PADDR_W-1:0] exp_wr_addr_q[$];
  logic [XLEN-1:0]    exp_wr_data_q[$];
  logic [7:0]         exp_wr_mask_q[$];
  logic [ID_W-1:0]    exp_id_q[$];
  logic [XLEN-1:0]    exp_q[$];
  logic               exp_err_q[$];
  int                 exp_lat_q[$];

  logic [XLEN-1:0] mem_dw = '0;
  bit drop_rd = 1'b0;
  bit bp_en = 1'b0;
  int cyc = 0, acc_cyc = 0;
  int rd_cnt = 0, wr_cnt = 0, resp_cnt = 0;
  int rd_fires = 0, rd_served = 0;
  bit in_flight = 1'b0;

  // memory responder and ready drivers
  initial begin
    int st_rd, st_wr, st_rs;
    st_rd = 0; st_wr = 0; st_rs = 0;
    forever begin
      @(posedge clk); #1;
      if (bp_en && rd_vld_o && st_rd < 3) begin rd_rdy_i = 1'b0; st_rd++; end
      else begin rd_rdy_i = 1'b1; if (rd_vld_o) st_rd = 0; end
      if (bp_en && wr_vld_o && st_wr < 3) begin wr_rdy_i = 1'b0; st_wr++; end
      else begin wr_rdy_i = 1'b1; if (wr_vld_o) st_wr = 0; end
      if (bp_en && resp_vld_o && st_rs < 3) begin resp_rdy_i = 1'b0; st_rs++; end
      else begin resp_rdy_i = 1'b1; if (resp_vld_o) st_rs = 0; end
      rd_resp_vld_i = (rd_fires != rd_served) && !drop_rd;
      rd_served = rd_fires;
      rd_resp_data_i = mem_dw;
    end
  end

  // monitor: handshakes, payload stability, scoreboard pops, latency
  initial begin
    bit rd_hold, wr_hold, rs_hold, rs_prev;
    logic [PADDR_W-1:0] rd_addr_p, wr_addr_p;
    logic [XLEN-1:0] wr_data_p, rs_data_p;
    logic [7:0] wr_mask_p;
    logic [ID_W-1:0] rs_id_p;
    logic rs_err_p;
    int lat;
    rd_hold = 0; wr_hold = 0; rs_hold = 0; rs_prev = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        in_flight = 0; rd_hold = 0; wr_hold = 0; rs_hold = 0; rs_prev = 0;
      end else begin
        chk("req_rdy", 64'(req_rdy_o), 64'(!in_flight));
        chk("busy", 64'(busy_o), 64'(in_flight));
        if (rd_hold) begin
          chk("rd_vld_hold", 64'(rd_vld_o), 64'd1);
          chk("rd_addr_hold", 64'(rd_addr_o), 64'(rd_addr_p));
        end
        if (wr_hold) begin
          chk("wr_vld_hold", 64'(wr_vld_o), 64'd1);
          chk("wr_data_hold", wr_data_o, wr_data_p);
          chk("wr_mask_hold", 64'(wr_mask_o), 64'(wr_mask_p));
          chk("wr_addr_hold", 64'(wr_addr_o), 64'(wr_addr_p));
        end
        if (rs_hold) begin
          chk("resp_vld_hold", 64'(resp_vld_o), 64'd1);
          chk("resp_data_hold", resp_data_o, rs_data_p);
          chk("resp_id_hold", 64'(resp_id_o), 64'(rs_id_p));
          chk("resp_err_hold", 64'(resp_err_o), 64'(rs_err_p));
        end
        if (resp_vld_o && !rs_prev && exp_lat_q.size() != 0) begin
          lat = exp_lat_q.pop_front();
          if (lat >= 0) chk("latency", 64'(cyc - acc_cyc), 64'(lat));
        end
        if (req_vld_i && req_rdy_o) begin in_flight = 1; acc_cyc = cyc; end
        if (rd_vld_o && rd_rdy_i) begin
          rd_cnt++; rd_fires++;
          chk("rd_expected", 64'(exp_rd_addr_q.size() != 0), 64'd1);
          if (exp_rd_addr_q.size() != 0) chk("rd_addr", 64'(rd_addr_o), 64'(exp_rd_addr_q.pop_front()));
        end
        if (wr_vld_o && wr_rdy_i) begin
          wr_cnt++;
          chk("wr_expected", 64'(exp_wr_data_q.size() != 0), 64'd1);
          if (exp_wr_data_q.size() != 0) begin
            chk("wr_addr", 64'(wr_addr_o), 64'(exp_wr_addr_q.pop_front()));
            chk("wr_data", wr_data_o, exp_wr_data_q.pop_front());
            chk("wr_mask", 64'(wr_mask_o), 64'(exp_wr_mask_q.pop_front()));
          end
        end
        if (resp_vld_o && resp_rdy_i) begin
          resp_cnt++;
          in_flight = 0;
          chk("resp_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            chk("resp_id", 64'(resp_id_o), 64'(exp_id_q.pop_front()));
            chk("resp_data", resp_data_o, exp_q.pop_front());
            chk("resp_err", 64'(resp_err_o), 64'(exp_err_q.pop_front()));
          end
        end
        rd_hold = rd_vld_o && !rd_rdy_i;   rd_addr_p = rd_addr_o;
        wr_hold = wr_vld_o && !wr_rdy_i;   wr_addr_p = wr_addr_o;
        wr_data_p = wr_data_o;             wr_mask_p = wr_mask_o;
        rs_hold = resp_vld_o && !resp_rdy_i;
        rs_data_p = resp_data_o; rs_id_p = resp_id_o; rs_err_p = resp_err_o;
        rs_prev = resp_vld_o;
      end
    end
  end

  // reference AMO model for the random section
  function automatic void model(input logic [3:0] op, input logic w, input logic [55:0] addr,
                                input logic [63:0] rs2, input logic [63:0] mem,
                                output logic [63:0] old, output logic [63:0] wdata,
                                output logic [7:0] mask);
    logic [31:0] word;
    logic [63:0] a, b, au, bu, nv;
    word = addr[2] ? mem[63:32] : mem[31:0];
    old = w ? {{32{word[31]}}, word} : mem;
    a = old;
    b = w ? {{32{rs2[31]}}, rs2[31:0]} : rs2;
    au = w ? {32'd0, word} : mem;
    bu = w ? {32'd0, rs2[31:0]} : rs2;
    case (op)
      4'd0: nv = rs2;
      4'd1: nv = a + b;
      4'd2: nv = a ^ b;
      4'd3: nv = a & b;
      4'd4: nv = a | b;
      4'd5: nv = ($signed(a) < $signed(b)) ? a : b;
      4'd6: nv = ($signed(a) < $signed(b)) ? b : a;
      4'd7: nv = (au < bu) ? a : b;
      default: nv = (au < bu) ? b : a;
    endcase
    wdata = w ? {nv[31:0], nv[31:0]} : nv;
    mask = w ? (addr[2] ? 8'hF0 : 8'h0F) : 8'hFF;
  endfunction

  // driver task: called and left at 1 time unit after a rising edge
  task automatic amo(input logic [3:0] id, input logic [3:0] op, input logic w,
                     input logic [55:0] addr, input logic [63:0] rs2, input logic [63:0] mem,
                     input logic err, input logic [63:0] e_old, input logic [63:0] e_wdata,
                     input logic [7:0] e_mask, input int e_lat, input int e_opc,
                     input int e_opw, input bit wait_resp);
    int rd0, wr0, rs0, k;
    rd0 = rd_cnt; wr0 = wr_cnt; rs0 = resp_cnt;
    mem_dw = mem;
    if (!err) exp_rd_addr_q.push_back({addr[55:3], 3'b000});
    if (wait_resp) begin
      if (!err) begin
        exp_wr_addr_q.push_back({addr[55:3], 3'b000});
        exp_wr_data_q.push_back(e_wdata);
        exp_wr_mask_q.push_back(e_mask);
      end
      exp_id_q.push_back(id);
      exp_q.push_back(e_old);
      exp_err_q.push_back(err);
      exp_lat_q.push_back(e_lat);
    end
    req_id_i = id; req_amo_op_i = op; req_w_i = w; req_addr_i = addr; req_data_i = rs2;
    req_vld_i = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!req_rdy_o && k < 60);
    chk("req_accept", 64'(req_rdy_o), 64'd1);
    @(posedge clk); #1;
    req_vld_i = 1'b0;
    req_data_i = 64'($urandom());
    if (e_opc >= 0) begin
      repeat (3) @(negedge clk);
      chk("alu_opcode", 64'(alu_opcode_o), 64'(e_opc));
      chk("alu_op_w", 64'(alu_op_w_o), 64'(e_opw));
    end
    if (wait_resp) begin
      for (int j = 0; j < 80 && resp_cnt == rs0; j++) @(posedge clk);
      #1;
      chk("resp_seen", 64'(resp_cnt - rs0), 64'd1);
      chk("rd_count", 64'(rd_cnt - rd0), 64'(!err));
      chk("wr_count", 64'(wr_cnt - wr0), 64'(!err));
    end else begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] m_old, m_wd, r_rs2, r_mem;
    logic [7:0] m_mask;
    logic [3:0] r_op;
    logic r_w;
    logic [55:0] r_addr;
    int rd0, wr0, rs0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_rdy", 64'(req_rdy_o), 64'd1);
    chk("rst_rd_vld", 64'(rd_vld_o), 64'd0);
    chk("rst_wr_vld", 64'(wr_vld_o), 64'd0);
    chk("rst_resp_vld", 64'(resp_vld_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_alu_opcode", 64'(alu_opcode_o), 64'(A_ADD));
    chk("rst_alu_operand0", alu_operand0_o, 64'd0);
    chk("rst_wr_mask", 64'(wr_mask_o), 64'd0);
    chk("rst_resp_data", resp_data_o, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    amo(4'd1, 4'd1, 1'b0, 56'h1000, 64'd5, 64'h10, 1'b0, 64'h10, 64'h15, 8'hFF, 5, int'(A_ADD), 0, 1);
    amo(4'd2, 4'd1, 1'b1, 56'h1004, 64'd1, 64'h7FFFFFFF_00000000, 1'b0, 64'h00000000_7FFFFFFF,
        64'h80000000_80000000, 8'hF0, 5, int'(A_ADD), 1, 1);
    amo(4'd3, 4'd5, 1'b1, 56'h2000, 64'd1, 64'h00000000_FFFFFFFF, 1'b0, 64'hFFFFFFFF_FFFFFFFF,
        64'hFFFFFFFF_FFFFFFFF, 8'h0F, 6, int'(A_SLT), 0, 1);
    amo(4'd4, 4'd7, 1'b1, 56'h2000, 64'd1, 64'h00000000_FFFFFFFF, 1'b0, 64'hFFFFFFFF_FFFFFFFF,
        64'h00000001_00000001, 8'h0F, 6, int'(A_SLTU), 0, 1);
    amo(4'd5, 4'd0, 1'b0, 56'h1003, 64'hDEAD, 64'h1234, 1'b1, 64'd0, 64'd0, 8'h00, 1, -1, -1, 1);
    amo(4'd6, 4'd1, 1'b1, 56'h1002, 64'd1, 64'h1234, 1'b1, 64'd0, 64'd0, 8'h00, 1, -1, -1, 1);
    amo(4'd7, 4'd9, 1'b0, 56'h1000, 64'd1, 64'h1234, 1'b1, 64'd0, 64'd0, 8'h00, 1, -1, -1, 1);
    amo(4'd8, 4'd6, 1'b0, 56'h2008, 64'd3, 64'hFFFFFFFF_FFFFFFFE, 1'b0, 64'hFFFFFFFF_FFFFFFFE,
        64'd3, 8'hFF, 6, int'(A_SLT), 0, 1);
    amo(4'd9, 4'd8, 1'b0, 56'h2008, 64'd3, 64'hFFFFFFFF_FFFFFFFE, 1'b0, 64'hFFFFFFFF_FFFFFFFE,
        64'hFFFFFFFF_FFFFFFFE, 8'hFF, 6, int'(A_SLTU), 0, 1);
    amo(4'd10, 4'd3, 1'b1, 56'h3000, 64'h0FF00FF0, 64'h12345678_F0F0F0F0, 1'b0,
        64'hFFFFFFFF_F0F0F0F0, 64'h00F000F0_00F000F0, 8'h0F, 5, int'(A_AND), 0, 1);

    // backpressure on every channel
    bp_en = 1'b1;
    amo(4'd11, 4'd4, 1'b0, 56'h3008, 64'hF0, 64'h0F, 1'b0, 64'h0F, 64'hFF, 8'hFF, -1, -1, -1, 1);
    bp_en = 1'b0;

    // reset while waiting for read data aborts the AMO
    drop_rd = 1'b1;
    rd0 = rd_cnt; wr0 = wr_cnt; rs0 = resp_cnt;
    amo(4'd12, 4'd1, 1'b0, 56'h5000, 64'd1, 64'd7, 1'b0, 64'd0, 64'd0, 8'h00, -1, -1, -1, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy_o), 64'd0);
    chk("abort_req_rdy", 64'(req_rdy_o), 64'd1);
    chk("abort_wr_vld", 64'(wr_vld_o), 64'd0);
    chk("abort_resp_vld", 64'(resp_vld_o), 64'd0);
    chk("abort_rd_count", 64'(rd_cnt - rd0), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    drop_rd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_no_wr", 64'(wr_cnt - wr0), 64'd0);
    chk("abort_no_resp", 64'(resp_cnt - rs0), 64'd0);
    amo(4'd13, 4'd2, 1'b0, 56'h5000, 64'hFF, 64'h0F, 1'b0, 64'h0F, 64'hF0, 8'hFF, 5, int'(A_XOR), 0, 1);

    // random legal AMOs checked against the reference model
    for (int i = 0; i < 10; i++) begin
      r_op = 4'($urandom_range(0, 8));
      r_w = 1'($urandom_range(0, 1));
      r_addr = 56'h4000 + 56'(8 * i) + (r_w ? 56'(4 * $urandom_range(0, 1)) : 56'd0);
      r_rs2 = {$urandom(), $urandom()};
      r_mem = {$urandom(), $urandom()};
      model(r_op, r_w, r_addr, r_rs2, r_mem, m_old, m_wd, m_mask);
      amo(4'(i), r_op, r_w, r_addr, r_rs2, r_mem, 1'b0, m_old, m_wd, m_mask,
          (r_op >= 4'd5) ? 6 : 5, -1, -1, 1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queues_drained", 64'(exp_q.size() + exp_wr_data_q.size() + exp_rd_addr_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
